// File: rtl/riscv_mmio_pkg.sv
// Memory-mapped I/O constants shared by the MEM stage, plus the UART
// transmitter state encoding.
package riscv_mmio_pkg;

    localparam logic [31:0] UART_TX_ADDR = 32'h2000_0000;
    localparam logic [31:0] DMEM_BASE    = 32'h1000_0000;
    localparam int unsigned DMEM_BYTES   = 131072;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers; full/empty/level are
// registered copies of the post-edge occupancy.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic             r_full, r_empty;
    logic [LW-1:0]    r_level;

    logic             w_push_ok, w_pop_ok;
    logic [PW-1:0]    w_wptr_nxt, w_rptr_nxt, w_diff_nxt;

    // A push is judged against the registered full flag only, so a pop on
    // the same edge never makes room for it.
    assign w_push_ok  = push && !r_full;
    assign w_pop_ok   = pop && !r_empty;
    assign w_wptr_nxt = r_wptr + PW'(w_push_ok);
    assign w_rptr_nxt = r_rptr + PW'(w_pop_ok);
    assign w_diff_nxt = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_level <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= (w_diff_nxt == PW'(DEPTH));
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_level <= LW'(w_diff_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr[AW-1:0]] <= push_data;
    end

    assign pop_data = r_mem[r_rptr[AW-1:0]];
    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;

endmodule

// File: rtl/uart_tx_stage.sv
// UART TX for MEM-stage byte stores: FIFO-buffered 8N1 serialiser, LSB first,
// with a sticky overflow flag for stores that arrive while the FIFO is full.
module uart_tx_stage
    import riscv_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [7:0]                       wr_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             busy,
    output logic                             overflow,
    input  logic                             ovf_clr,
    output logic                             tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    uart_state_e r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx, r_ovf;

    logic          w_full, w_empty, w_pop, w_bit_end;
    logic [7:0]    w_head;

    assign w_bit_end = (r_baud == BAUD_MAX);
    // Pop when idle, or at the end of a stop bit so frames run back to back.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || (r_state == ST_STOP && w_bit_end));

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_baud  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_bit   <= '0;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A new overflow event beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (wr_en && w_full)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign overflow = r_ovf;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench: small instance (4 clk/bit, depth 4) with a line decoder,
// plus a full-rate instance (868 clk/bit) for frame length.
module tb_uart_tx_stage;
    localparam int CPB_A = 4;

    logic clk, rst_n;
    logic wr_en_a, ovf_clr_a, full_a, empty_a, busy_a, ovf_a, tx_a;
    logic [7:0] wr_data_a;
    logic [2:0] level_a;
    logic wr_en_b, ovf_clr_b, full_b, empty_b, busy_b, ovf_b, tx_b;
    logic [7:0] wr_data_b;
    logic [4:0] level_b;

    int n_chk = 0, n_err = 0, cyc = 0;

    uart_tx_stage #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .full(full_a), .empty(empty_a), .level(level_a), .busy(busy_a),
        .overflow(ovf_a), .ovf_clr(ovf_clr_a), .tx(tx_a)
    );

    uart_tx_stage #(.CLKS_PER_BIT(868), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .full(full_b), .empty(empty_b), .level(level_b), .busy(busy_b),
        .overflow(ovf_b), .ovf_clr(ovf_clr_b), .tx(tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    // Line decoder for dut_a: samples mid-bit, records byte and start cycle.
    byte unsigned rxq[$];
    int rxt[$];
    int rx_ferr = 0;

    initial begin : mon
        logic [7:0] b;
        int t0;
        b = '0;
        forever begin
            step();
            if (rst_n && tx_a === 1'b0) begin
                t0 = cyc;
                wait_n(CPB_A / 2);
                if (tx_a !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    wait_n(CPB_A);
                    b[i] = tx_a;
                end
                wait_n(CPB_A);
                if (tx_a !== 1'b1) rx_ferr++;
                wait_n(1);
                rxq.push_back(b);
                rxt.push_back(t0);
            end
        end
    end

    task automatic rx_clear();
        rxq.delete();
        rxt.delete();
        rx_ferr = 0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : main
        logic [9:0] f55;
        logic [7:0] b;
        int peak, lows, n, el;
        byte unsigned exp4[6];

        f55 = 10'b1010101010;
        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h88};
        rst_n = 1'b0;
        wr_en_a = 0; wr_data_a = '0; ovf_clr_a = 0;
        wr_en_b = 0; wr_data_b = '0; ovf_clr_b = 0;

        // reset state
        wait_n(3);
        chk("rst_tx", tx_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_level", level_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_tx_b", tx_b, 1);
        rst_n = 1'b1;
        wait_n(3);
        chk("idle_tx", tx_a, 1);
        chk("idle_busy", busy_a, 0);

        // single 0x55 frame, cycle by cycle
        rx_clear();
        wr_en_a = 1; wr_data_a = 8'h55;
        step();
        wr_en_a = 0;
        chk("s1_tx_push_edge", tx_a, 1);
        chk("s1_level", level_a, 1);
        chk("s1_busy", busy_a, 1);
        for (int i = 0; i < 40; i++) begin
            step();
            chk($sformatf("s1_bit%0d", i / 4), tx_a, f55[i / 4]);
            if (i == 0) chk("s1_level_pop", level_a, 0);
        end
        chk("s1_busy_stop", busy_a, 1);
        step();
        chk("s1_busy_end", busy_a, 0);
        chk("s1_tx_end", tx_a, 1);
        chk("s1_rx_n", rxq.size(), 1);
        chk("s1_rx_b", rxq[0], 8'h55);

        // A, B, C back to back
        wait_n(5);
        rx_clear();
        wr_en_a = 1; wr_data_a = 8'h41; step();
        chk("s2_lvl0", level_a, 1);
        wr_data_a = 8'h42; step();
        chk("s2_lvl1", level_a, 1);
        wr_data_a = 8'h43; step();
        chk("s2_lvl2", level_a, 2);
        wr_en_a = 0;
        peak = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            if (int'(level_a) > peak) peak = int'(level_a);
        end
        chk("s2_peak", peak, 2);
        chk("s2_rx_n", rxq.size(), 3);
        chk("s2_rx0", rxq[0], 8'h41);
        chk("s2_rx1", rxq[1], 8'h42);
        chk("s2_rx2", rxq[2], 8'h43);
        chk("s2_gap01", rxt[1] - rxt[0], 40);
        chk("s2_gap12", rxt[2] - rxt[1], 40);
        chk("s2_ferr", rx_ferr, 0);
        chk("s2_busy", busy_a, 0);

        // fill, overflow, clear, push-at-pop rejection
        rx_clear();
        wr_en_a = 1; wr_data_a = 8'h10; step();
        wr_data_a = 8'h11; step();
        wr_data_a = 8'h12; step();
        wr_data_a = 8'h13; step();
        wr_data_a = 8'h14; step();
        chk("s3_full", full_a, 1);
        chk("s3_level", level_a, 4);
        chk("s3_ovf_pre", ovf_a, 0);
        wr_data_a = 8'hEE; step();
        chk("s3_ovf_set", ovf_a, 1);
        chk("s3_level_ovf", level_a, 4);
        wr_en_a = 0; ovf_clr_a = 1; step();
        ovf_clr_a = 0;
        chk("s3_ovf_clr", ovf_a, 0);
        wait_n(34);
        chk("s3_full_prepop", full_a, 1);
        wr_en_a = 1; wr_data_a = 8'h77; step();
        chk("s3_pop_ovf", ovf_a, 1);
        chk("s3_pop_full", full_a, 0);
        chk("s3_pop_level", level_a, 3);
        wr_data_a = 8'h88; step();
        chk("s3_repush_level", level_a, 4);
        chk("s3_repush_full", full_a, 1);
        wr_en_a = 0; ovf_clr_a = 1; step();
        chk("s3_clr2", ovf_a, 0);
        wr_en_a = 1; wr_data_a = 8'h99; step();
        chk("s3_set_wins", ovf_a, 1);
        chk("s3_set_wins_lvl", level_a, 4);
        wr_en_a = 0; step();
        ovf_clr_a = 0;
        chk("s3_clr3", ovf_a, 0);
        wait_n(250);
        chk("s3_rx_n", rxq.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("s3_rx%0d", i), rxq[i], exp4[i]);
        chk("s3_ferr", rx_ferr, 0);
        chk("s3_busy", busy_a, 0);

        // reset mid-DATA with bytes queued
        wr_en_a = 1; wr_data_a = 8'hA5; step();
        wr_data_a = 8'hB1; step();
        wr_data_a = 8'hB2; step();
        wr_en_a = 0;
        chk("s4_level", level_a, 2);
        wait_n(10);
        rst_n = 1'b0;
        #1;
        chk("s4_tx", tx_a, 1);
        chk("s4_level_rst", level_a, 0);
        chk("s4_busy_rst", busy_a, 0);
        chk("s4_empty_rst", empty_a, 1);
        wait_n(2);
        rst_n = 1'b1;
        wait_n(60);
        rx_clear();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_a !== 1'b1) lows++;
        end
        chk("s4_no_frame", lows, 0);
        chk("s4_rx_n", rxq.size(), 0);
        chk("s4_busy", busy_a, 0);

        // full-rate frame of 0x0D
        wr_en_b = 1; wr_data_b = 8'h0D; step();
        wr_en_b = 0;
        chk("s5_tx_push_edge", tx_b, 1);
        n = 0;
        while (tx_b !== 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("s5_fall_lat", n, 1);
        wait_n(434);
        chk("s5_start", tx_b, 0);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            wait_n(868);
            b[i] = tx_b;
        end
        wait_n(868);
        chk("s5_stop", tx_b, 1);
        chk("s5_byte", b, 8'h0D);
        el = 434 + 9 * 868;
        while (busy_b !== 1'b0 && el < 10000) begin
            step();
            el++;
        end
        chk("s5_frame_len", el, 8680);
        chk("s5_tx_end", tx_b, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
